// File: rtl/usb_sie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_sie_pkg
// Description : Shared types and constants for the USB SIE receive path:
//               line-state encoding, receive FSM states, counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_sie_pkg;

  // Classified line state. SE1 is folded into SE0 by line_class().
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_CHK = 3'd3,
    ABORT   = 3'd4
  } rx_state_e;

  // Default run of decoded ones after which a stuffed zero is expected
  localparam int STUFF_LEN_DEFAULT = 6;

  // Width of the saturating run-length counters
  localparam int CNT_W = 8;

  // Map a raw D+/D- sample onto J, K or SE0 (SE1 treated as SE0)
  function automatic logic [1:0] line_class(input logic dp, input logic dm);
    logic [1:0] ls;
    ls = LS_SE0;
    if (dp && !dm) begin
      ls = LS_J;
    end else if (!dp && dm) begin
      ls = LS_K;
    end
    return ls;
  endfunction

endpackage : usb_sie_pkg
`default_nettype wire

// File: rtl/usb_rx_nrzi_unstuff_nrzi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nrzi_decoder
// Description : Classifies the sampled line and NRZI-decodes J/K bits against
//               the previously seen J/K state. SE0 leaves the history alone.
// Revision    : 1.0 - initial release
// ============================================================================
module nrzi_decoder
  import usb_sie_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       BIT_EN,
  input  logic       dp_i,
  input  logic       dm_i,
  input  logic       force_j_i,   // reload history with J (packet exit)
  output logic       dbit_o,      // decoded bit, meaningful only for J/K
  output logic [1:0] line_cls_o   // LS_J / LS_K / LS_SE0
);

  logic [1:0] prev_line_q;
  logic [1:0] prev_line_d;

  // Classify the line, decode against history and compute the next history
  always_comb begin
    line_cls_o  = line_class(dp_i, dm_i);
    dbit_o      = (line_cls_o == prev_line_q);
    prev_line_d = prev_line_q;
    if (BIT_EN) begin
      if (force_j_i) begin
        prev_line_d = LS_J;
      end else if (line_cls_o != LS_SE0) begin
        prev_line_d = line_cls_o;
      end
    end
  end

  // Line history register; idle bus is J
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_line_q <= LS_J;
    end else begin
      prev_line_q <= prev_line_d;
    end
  end

endmodule : nrzi_decoder
`default_nettype wire

// File: rtl/usb_rx_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_nrzi_unstuff
// Description : USB receive front end: SYNC detection, bit unstuffing, EOP
//               detection. Emits a qualified LSB-first serial stream with
//               SOP/EOP/RX_ERR pulses for the packet layer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_nrzi_unstuff
  import usb_sie_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int STUFF_LEN      = STUFF_LEN_DEFAULT,
  parameter int EOP_SE0_BITS   = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic BIT_EN,
  input  logic DP,
  input  logic DM,
  output logic SER_OP,
  output logic BIT_VALID,
  output logic SOP,
  output logic EOP,
  output logic RX_ERR,
  output logic ACTIVE
);

  localparam logic [CNT_W-1:0] SYNC_MIN_C  = CNT_W'(SYNC_MIN_ZEROS);
  localparam logic [CNT_W-1:0] STUFF_C     = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] EOP_SE0_C   = CNT_W'(EOP_SE0_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};
  localparam logic [3:0]       ABORT_J_LAST = 4'd7;

  logic       dbit;
  logic [1:0] line_cls;
  logic       force_j;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       abort_j_cnt_q, abort_j_cnt_d;
  logic             abort_se0_q, abort_se0_d;
  logic             ser_op_q, ser_op_d;
  logic             bit_valid_q, bit_valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             rx_err_q, rx_err_d;
  logic             active_q, active_d;

  nrzi_decoder u_nrzi_decoder (
    .CLK        (CLK),
    .RST        (RST),
    .BIT_EN     (BIT_EN),
    .dp_i       (DP),
    .dm_i       (DM),
    .force_j_i  (force_j),
    .dbit_o     (dbit),
    .line_cls_o (line_cls)
  );

  // Next-state, counter and pulse logic; everything advances only on BIT_EN
  always_comb begin
    state_d       = state_q;
    zero_cnt_d    = zero_cnt_q;
    ones_cnt_d    = ones_cnt_q;
    se0_cnt_d     = se0_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    abort_j_cnt_d = abort_j_cnt_q;
    abort_se0_d   = abort_se0_q;
    ser_op_d      = ser_op_q;
    active_d      = active_q;
    bit_valid_d   = 1'b0;
    sop_d         = 1'b0;
    eop_d         = 1'b0;
    rx_err_d      = 1'b0;
    force_j       = 1'b0;

    if (BIT_EN) begin
      unique case (state_q)
        IDLE: begin
          // The J->K edge that starts SYNC is itself the first zero
          if (line_cls == LS_K) begin
            state_d    = SYNC;
            zero_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        SYNC: begin
          if (line_cls == LS_SE0) begin
            state_d = IDLE;
          end else if (!dbit) begin
            if (zero_cnt_q != CNT_MAX_C) begin
              zero_cnt_d = zero_cnt_q + 1'b1;
            end
          end else if (zero_cnt_q >= SYNC_MIN_C) begin
            // SYNC's closing one is the first of any stuffing run
            state_d    = DATA;
            sop_d      = 1'b1;
            active_d   = 1'b1;
            ones_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            bit_cnt_d  = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (line_cls == LS_SE0) begin
            state_d   = EOP_CHK;
            se0_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (ones_cnt_q == STUFF_C) begin
            if (!dbit) begin
              ones_cnt_d = '0;
            end else begin
              rx_err_d      = 1'b1;
              active_d      = 1'b0;
              state_d       = ABORT;
              abort_se0_d   = 1'b0;
              abort_j_cnt_d = 4'd0;
            end
          end else begin
            ser_op_d    = dbit;
            bit_valid_d = 1'b1;
            bit_cnt_d   = bit_cnt_q + 3'd1;
            ones_cnt_d  = dbit ? (ones_cnt_q + 1'b1) : '0;
          end
        end

        EOP_CHK: begin
          if (line_cls == LS_SE0) begin
            if (se0_cnt_q != CNT_MAX_C) begin
              se0_cnt_d = se0_cnt_q + 1'b1;
            end
          end else if ((line_cls == LS_J) && (se0_cnt_q >= EOP_SE0_C)) begin
            state_d  = IDLE;
            active_d = 1'b0;
            eop_d    = 1'b1;
            rx_err_d = (bit_cnt_q != 3'd0);
            force_j  = 1'b1;
          end else begin
            state_d       = ABORT;
            active_d      = 1'b0;
            rx_err_d      = 1'b1;
            force_j       = 1'b1;
            abort_se0_d   = 1'b0;
            abort_j_cnt_d = 4'd0;
          end
        end

        ABORT: begin
          // Recover on SE0 followed by J, or on eight consecutive J bits
          if (line_cls == LS_SE0) begin
            abort_se0_d   = 1'b1;
            abort_j_cnt_d = 4'd0;
          end else if (line_cls == LS_J) begin
            if (abort_se0_q || (abort_j_cnt_q == ABORT_J_LAST)) begin
              state_d       = IDLE;
              force_j       = 1'b1;
              abort_se0_d   = 1'b0;
              abort_j_cnt_d = 4'd0;
            end else begin
              abort_j_cnt_d = abort_j_cnt_q + 4'd1;
            end
          end else begin
            abort_se0_d   = 1'b0;
            abort_j_cnt_d = 4'd0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      zero_cnt_q    <= '0;
      ones_cnt_q    <= '0;
      se0_cnt_q     <= '0;
      bit_cnt_q     <= 3'd0;
      abort_j_cnt_q <= 4'd0;
      abort_se0_q   <= 1'b0;
      ser_op_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      rx_err_q      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      zero_cnt_q    <= zero_cnt_d;
      ones_cnt_q    <= ones_cnt_d;
      se0_cnt_q     <= se0_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      abort_j_cnt_q <= abort_j_cnt_d;
      abort_se0_q   <= abort_se0_d;
      ser_op_q      <= ser_op_d;
      bit_valid_q   <= bit_valid_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      rx_err_q      <= rx_err_d;
      active_q      <= active_d;
    end
  end

  assign SER_OP    = ser_op_q;
  assign BIT_VALID = bit_valid_q;
  assign SOP       = sop_q;
  assign EOP       = eop_q;
  assign RX_ERR    = rx_err_q;
  assign ACTIVE    = active_q;

endmodule : usb_rx_nrzi_unstuff
`default_nettype wire
